// File: rtl/pll_freq_lock_mon.sv
// Reference-clock frequency monitor with hysteretic lock detection.
// The asynchronous reference is synchronised, edge-detected and divided by
// 2^REF_DIV_LOG2 to form a measurement gate. The number of system clocks per
// gate is compared against a runtime nominal/tolerance window. The result
// drives a lock state machine and fast/slow correction hints.
`timescale 1ns/1ps

module pll_freq_lock_mon #(
  parameter int REF_DIV_LOG2 = 13,
  parameter int CNT_W        = 21,
  parameter int LOCK_CNT     = 4,
  parameter int UNLOCK_CNT   = 2,
  parameter int SYNC_STAGES  = 3
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ref_i,
  input  logic             cfg_en_i,
  input  logic [CNT_W-1:0] nominal_i,
  input  logic [CNT_W-1:0] tol_i,
  output logic [CNT_W-1:0] meas_o,
  output logic [CNT_W:0]   err_o,
  output logic             meas_valid_o,
  output logic             timeout_o,
  output logic             in_window_o,
  output logic             fast_o,
  output logic             slow_o,
  output logic             lock_o,
  output logic             ok_o
);

  // Signed comparison width: one extra bit so nominal+tol never wraps and
  // one sign bit so nominal-tol may go negative.
  localparam int SW = CNT_W + 2;

  localparam logic [REF_DIV_LOG2-1:0] EDGE_ONE  = REF_DIV_LOG2'(1);
  localparam logic [REF_DIV_LOG2-1:0] EDGE_LAST = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic [3:0]              LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0]              UNLOCK_LAST = 4'(UNLOCK_CNT - 1);
  localparam logic [3:0]              CNT4_ONE    = 4'(1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARM      = 2'd1,
    UNLOCKED = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  ref_sync;
  logic                    ref_last;
  logic                    edge_stb;
  logic [REF_DIV_LOG2-1:0] edge_cnt;
  logic [CNT_W-1:0]        meas_cnt;
  logic [3:0]              good_cnt;
  logic [3:0]              bad_cnt;

  logic                    boundary;
  logic                    saturated;
  logic signed [SW-1:0]    meas_s;
  logic signed [SW-1:0]    nom_s;
  logic signed [SW-1:0]    tol_s;
  logic signed [SW-1:0]    lo_lim;
  logic signed [SW-1:0]    hi_lim;
  logic [CNT_W:0]          err_calc;
  logic                    cmp_fast;
  logic                    cmp_slow;
  logic                    cmp_in;

  // Reference synchroniser chain followed by a registered rising-edge strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ref_sync <= '0;
      ref_last <= 1'b0;
      edge_stb <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_i};
      ref_last <= ref_sync[SYNC_STAGES-1];
      edge_stb <= ref_sync[SYNC_STAGES-1] & ~ref_last;
    end
  end

  // Gate boundary, saturation and window comparison of the running count.
  always_comb begin
    boundary  = edge_stb && (edge_cnt == EDGE_LAST);
    saturated = (meas_cnt == CNT_MAX);
    meas_s    = $signed({2'b00, meas_cnt});
    nom_s     = $signed({2'b00, nominal_i});
    tol_s     = $signed({2'b00, tol_i});
    lo_lim    = nom_s - tol_s;
    hi_lim    = nom_s + tol_s;
    // The difference always fits CNT_W+1 signed bits, so modular
    // subtraction yields the exact two's complement error.
    err_calc  = {1'b0, meas_cnt} - {1'b0, nominal_i};
    cmp_fast  = (meas_s < lo_lim);
    cmp_slow  = (meas_s > hi_lim);
    cmp_in    = ~cmp_fast & ~cmp_slow;
  end

  // Lock state machine together with the gate counters and result registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= DISABLED;
      edge_cnt     <= '0;
      meas_cnt     <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      meas_o       <= '0;
      err_o        <= '0;
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      in_window_o  <= 1'b0;
      fast_o       <= 1'b0;
      slow_o       <= 1'b0;
      lock_o       <= 1'b0;
    end else if (!cfg_en_i) begin
      // Disable overrides everything, including a coincident boundary;
      // the last measurement and error are deliberately held.
      state        <= DISABLED;
      edge_cnt     <= '0;
      meas_cnt     <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      in_window_o  <= 1'b0;
      fast_o       <= 1'b0;
      slow_o       <= 1'b0;
      lock_o       <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;

      if (edge_stb) begin
        edge_cnt <= edge_cnt + EDGE_ONE;
      end
      if (boundary) begin
        meas_cnt <= CNT_ONE;
      end else if (!saturated) begin
        meas_cnt <= meas_cnt + CNT_ONE;
      end

      case (state)
        DISABLED: begin
          state <= ARM;
        end

        ARM: begin
          // The first boundary only opens a gate; saturation here is silent.
          if (boundary) begin
            state <= UNLOCKED;
          end
        end

        UNLOCKED, LOCKED: begin
          if (boundary) begin
            meas_o       <= meas_cnt;
            err_o        <= err_calc;
            in_window_o  <= cmp_in;
            fast_o       <= cmp_fast;
            slow_o       <= cmp_slow;
            meas_valid_o <= 1'b1;
            if (state == UNLOCKED) begin
              if (!cmp_in) begin
                good_cnt <= '0;
              end else if (good_cnt == LOCK_LAST) begin
                good_cnt <= '0;
                lock_o   <= 1'b1;
                state    <= LOCKED;
              end else begin
                good_cnt <= good_cnt + CNT4_ONE;
              end
            end else begin
              if (cmp_in) begin
                bad_cnt <= '0;
              end else if (bad_cnt == UNLOCK_LAST) begin
                bad_cnt <= '0;
                lock_o  <= 1'b0;
                state   <= UNLOCKED;
              end else begin
                bad_cnt <= bad_cnt + CNT4_ONE;
              end
            end
          end else if (saturated) begin
            // Reference lost: report a maximal slow result, drop lock at
            // once and re-arm from a clean edge count.
            meas_o       <= CNT_MAX;
            err_o        <= err_calc;
            in_window_o  <= 1'b0;
            fast_o       <= 1'b0;
            slow_o       <= 1'b1;
            lock_o       <= 1'b0;
            meas_valid_o <= 1'b1;
            timeout_o    <= 1'b1;
            edge_cnt     <= '0;
            meas_cnt     <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            state        <= ARM;
          end
        end

        default: begin
          state <= DISABLED;
        end
      endcase
    end
  end

  // Healthy when locked, or when monitoring is intentionally switched off.
  assign ok_o = lock_o | ~cfg_en_i;

endmodule

// File: tb/tb_pll_freq_lock_mon.sv
// Directed bench for pll_freq_lock_mon with small gate parameters.
// A reference generator emits groups of 16 reference periods whose total
// length comes from a queue; group 0 after each (re)start is the ARM gate.
`timescale 1ns/1ps

module tb_pll_freq_lock_mon;

  localparam int REF_DIV_LOG2 = 4;
  localparam int CNT_W        = 12;
  localparam int LOCK_CNT     = 3;
  localparam int UNLOCK_CNT   = 2;
  localparam int SYNC_STAGES  = 3;

  logic             clk_i;
  logic             rstn_i;
  logic             ref_i;
  logic             cfg_en_i;
  logic [CNT_W-1:0] nominal_i;
  logic [CNT_W-1:0] tol_i;
  logic [CNT_W-1:0] meas_o;
  logic [CNT_W:0]   err_o;
  logic             meas_valid_o;
  logic             timeout_o;
  logic             in_window_o;
  logic             fast_o;
  logic             slow_o;
  logic             lock_o;
  logic             ok_o;

  int checks   = 0;
  int failures = 0;

  bit gen_run   = 0;
  int edges_sent = 0;
  int gate_q[$];

  pll_freq_lock_mon #(
    .REF_DIV_LOG2(REF_DIV_LOG2),
    .CNT_W       (CNT_W),
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_CNT  (UNLOCK_CNT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .ref_i       (ref_i),
    .cfg_en_i    (cfg_en_i),
    .nominal_i   (nominal_i),
    .tol_i       (tol_i),
    .meas_o      (meas_o),
    .err_o       (err_o),
    .meas_valid_o(meas_valid_o),
    .timeout_o   (timeout_o),
    .in_window_o (in_window_o),
    .fast_o      (fast_o),
    .slow_o      (slow_o),
    .lock_o      (lock_o),
    .ok_o        (ok_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference generator: each period ends with a rising edge driven on a
  // falling clock edge; a gate of length L uses 16 periods of 9/10/11.
  initial begin
    ref_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (gen_run) begin
        edges_sent = 0;
        while (gen_run) begin
          int len;
          len = (gate_q.size() > 0) ? gate_q.pop_front() : 160;
          for (int i = 0; i < 16 && gen_run; i++) begin
            int per;
            per = 10;
            if (len > 160 && i < len - 160) per = 11;
            if (len < 160 && i < 160 - len) per = 9;
            for (int c = 1; c <= per; c++) begin
              @(negedge clk_i);
              if (c == 2) ref_i = 1'b0;
              if (c == per) begin
                ref_i = 1'b1;
                edges_sent++;
              end
            end
          end
        end
        ref_i = 1'b0;
      end
    end
  end

  function automatic logic [31:0] e13(input int v);
    logic [12:0] t;
    t = 13'(v);
    return {19'b0, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (meas_valid_o) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic chk_result(input string tag, input int m, input int e,
                            input bit inw, input bit f, input bit s, input bit lk);
    bit got;
    wait_valid(1000, got);
    chk({tag, ".valid"}, 32'(got), 32'(1));
    if (got) begin
      $display("result %s meas=%0d err=%0d in=%0b fast=%0b slow=%0b lock=%0b",
               tag, meas_o, $signed(err_o), in_window_o, fast_o, slow_o, lock_o);
      chk({tag, ".meas"},  32'(meas_o),      32'(m));
      chk({tag, ".err"},   {19'b0, err_o},   e13(e));
      chk({tag, ".in"},    32'(in_window_o), 32'(inw));
      chk({tag, ".fast"},  32'(fast_o),      32'(f));
      chk({tag, ".slow"},  32'(slow_o),      32'(s));
      chk({tag, ".lock"},  32'(lock_o),      32'(lk));
      chk({tag, ".tmo"},   32'(timeout_o),   32'(0));
    end
  endtask

  initial begin
    bit got;
    int pulses;

    rstn_i    = 1'b0;
    cfg_en_i  = 1'b0;
    nominal_i = 12'd160;
    tol_i     = 12'd2;
    repeat (5) @(posedge clk_i);
    #1;
    chk("rst.meas",  32'(meas_o),       32'(0));
    chk("rst.err",   {19'b0, err_o},    e13(0));
    chk("rst.valid", 32'(meas_valid_o), 32'(0));
    chk("rst.tmo",   32'(timeout_o),    32'(0));
    chk("rst.in",    32'(in_window_o),  32'(0));
    chk("rst.fast",  32'(fast_o),       32'(0));
    chk("rst.slow",  32'(slow_o),       32'(0));
    chk("rst.lock",  32'(lock_o),       32'(0));
    chk("rst.ok",    32'(ok_o),         32'(1));
    rstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    // Group 0 is the discarded ARM gate; then the full directed sequence.
    gate_q = '{160, 160, 160, 160, 162, 163, 162, 163, 163,
               157, 157, 157, 157, 160, 160, 160, 163, 160, 157, 160};
    cfg_en_i = 1'b1;
    gen_run  = 1;

    chk_result("lock1", 160, 0, 1, 0, 0, 0);
    chk_result("lock2", 160, 0, 1, 0, 0, 0);
    chk_result("lock3", 160, 0, 1, 0, 0, 1);
    chk("lock3.ok", 32'(ok_o), 32'(1));
    chk_result("bnd162a", 162, 2, 1, 0, 0, 1);
    chk_result("bnd163a", 163, 3, 0, 0, 1, 1);
    chk_result("bnd162b", 162, 2, 1, 0, 0, 1);
    chk_result("bnd163b", 163, 3, 0, 0, 1, 1);
    chk_result("bnd163c", 163, 3, 0, 0, 1, 0);
    chk("unlock.ok", 32'(ok_o), 32'(0));
    chk_result("fast1", 157, -3, 0, 1, 0, 0);
    chk_result("fast2", 157, -3, 0, 1, 0, 0);
    chk_result("fast3", 157, -3, 0, 1, 0, 0);
    chk_result("fast4", 157, -3, 0, 1, 0, 0);
    chk_result("relk1", 160, 0, 1, 0, 0, 0);
    chk_result("relk2", 160, 0, 1, 0, 0, 0);
    chk_result("relk3", 160, 0, 1, 0, 0, 1);
    chk_result("hys_bad1",  163, 3, 0, 0, 1, 1);
    chk_result("hys_good1", 160, 0, 1, 0, 0, 1);
    chk_result("hys_bad2",  157, -3, 0, 1, 0, 1);
    chk_result("hys_good2", 160, 0, 1, 0, 0, 1);

    // Stop the reference while locked: one timeout pulse, then silence.
    gen_run = 0;
    wait_valid(5000, got);
    chk("tmo.valid", 32'(got), 32'(1));
    if (got) begin
      $display("timeout meas=%0d err=%0d lock=%0b", meas_o, $signed(err_o), lock_o);
      chk("tmo.pulse", 32'(timeout_o),   32'(1));
      chk("tmo.meas",  32'(meas_o),      32'(4095));
      chk("tmo.err",   {19'b0, err_o},   e13(3935));
      chk("tmo.in",    32'(in_window_o), 32'(0));
      chk("tmo.fast",  32'(fast_o),      32'(0));
      chk("tmo.slow",  32'(slow_o),      32'(1));
      chk("tmo.lock",  32'(lock_o),      32'(0));
      chk("tmo.ok",    32'(ok_o),        32'(0));
      @(posedge clk_i);
      #1;
      chk("tmo.valid_once", 32'(meas_valid_o), 32'(0));
      chk("tmo.tmo_once",   32'(timeout_o),    32'(0));
    end
    pulses = 0;
    for (int i = 0; i < 4400; i++) begin
      @(posedge clk_i);
      #1;
      if (meas_valid_o) pulses++;
    end
    chk("arm_sat.no_pulse", 32'(pulses), 32'(0));

    // Restore the reference: ARM gate, then three gates to relock.
    gate_q = '{160, 160, 160, 160};
    gen_run = 1;
    chk_result("rto1", 160, 0, 1, 0, 0, 0);
    chk_result("rto2", 160, 0, 1, 0, 0, 0);
    chk_result("rto3", 160, 0, 1, 0, 0, 1);

    // Drop enable in the boundary cycle of the next gate (edge 80 of this run);
    // the boundary strobe is seen four clocks after the reference rises.
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i);
      if (edges_sent == 80) begin
        got = 1;
        break;
      end
    end
    chk("dis.edge_seen", 32'(got), 32'(1));
    repeat (3) @(posedge clk_i);
    #1;
    cfg_en_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i);
      #1;
      if (meas_valid_o) pulses++;
    end
    $display("disable pulses=%0d lock=%0b ok=%0b meas=%0d", pulses, lock_o, ok_o, meas_o);
    chk("dis.no_valid", 32'(pulses),      32'(0));
    chk("dis.lock",     32'(lock_o),      32'(0));
    chk("dis.ok",       32'(ok_o),        32'(1));
    chk("dis.in",       32'(in_window_o), 32'(0));
    chk("dis.meas_hold", 32'(meas_o),     32'(160));

    // Re-enable with a fresh reference run, then reset in the middle of a gate.
    gen_run = 0;
    repeat (20) @(posedge clk_i);
    #1;
    cfg_en_i = 1'b1;
    gen_run  = 1;
    chk_result("ren1", 160, 0, 1, 0, 0, 0);
    repeat (50) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    #1;
    $display("reset meas=%0d in=%0b lock=%0b ok=%0b", meas_o, in_window_o, lock_o, ok_o);
    chk("mrst.meas",  32'(meas_o),       32'(0));
    chk("mrst.err",   {19'b0, err_o},    e13(0));
    chk("mrst.in",    32'(in_window_o),  32'(0));
    chk("mrst.valid", 32'(meas_valid_o), 32'(0));
    chk("mrst.lock",  32'(lock_o),       32'(0));
    chk("mrst.ok",    32'(ok_o),         32'(0));
    gen_run = 0;
    repeat (20) @(posedge clk_i);
    #1;
    rstn_i  = 1'b1;
    gen_run = 1;
    chk_result("post_rst1", 160, 0, 1, 0, 0, 0);
    chk_result("post_rst2", 160, 0, 1, 0, 0, 0);
    chk_result("post_rst3", 160, 0, 1, 0, 0, 1);
    gen_run = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
